// File: rtl/branch_outcome_tracker_pkg.sv
// Shared constants and types for the branch outcome tracker.
// Contents: boolean constants, 2-bit predictor state encodings, default
// BTB/queue sizes, the queue entry payload struct and a redirect helper.
package branch_outcome_tracker_pkg;

  localparam bit TRUE  = 1'b1;
  localparam bit FALSE = 1'b0;

  // 2-bit saturating predictor state encodings
  localparam logic [1:0] ST_STRONG_NT = 2'b00;
  localparam logic [1:0] ST_WEAK_NT   = 2'b01;
  localparam logic [1:0] ST_WEAK_T    = 2'b10;
  localparam logic [1:0] ST_STRONG_T  = 2'b11;

  localparam int unsigned DEF_BTB_DEPTH   = 64;
  localparam int unsigned DEF_QUEUE_DEPTH = 8;
  localparam int unsigned DEF_TAG_W       = 3;
  localparam int unsigned ADDR_W          = 32;

  // Fields captured from fetch at push time
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] target;
    logic              pred;
  } br_entry_t;

  // Correct next PC after a mispredict: taken target or fall-through (wraps)
  function automatic logic [ADDR_W-1:0] redirect_pc(input br_entry_t e, input logic actual);
    return actual ? e.target : ADDR_W'(e.pc + 32'd4);
  endfunction

endpackage

// File: rtl/branch_tag_queue.sv
// Circular tag queue holding in-flight predicted branches.
// Ports: clk_i/rst_n_i; push_i + push_entry_i write at tail; res_i marks
// res_tag_i resolved with res_taken_i; pop_i retires head; clear_i empties
// everything. Exposes head/tail/count, full, head entry state and whether the
// tag being resolved is still open (valid and unresolved).
module branch_tag_queue
  import branch_outcome_tracker_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_QUEUE_DEPTH,
  parameter int unsigned TAG_W = DEF_TAG_W
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  br_entry_t        push_entry_i,
  input  logic             res_i,
  input  logic [TAG_W-1:0] res_tag_i,
  input  logic             res_taken_i,
  input  logic             pop_i,
  input  logic             clear_i,
  output logic [TAG_W-1:0] head_o,
  output logic [TAG_W-1:0] tail_o,
  output logic [TAG_W:0]   count_o,
  output logic             full_o,
  output logic             res_open_o,
  output logic             head_valid_o,
  output logic             head_resolved_o,
  output br_entry_t        head_entry_o,
  output logic             head_actual_o
);

  localparam int unsigned CNT_W = TAG_W + 1;

  br_entry_t        entry_q [DEPTH];
  logic [DEPTH-1:0] actual_q;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] resolved_q, resolved_d;
  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointer/flag next state; clear overrides everything else
  always_comb begin
    valid_d    = valid_q;
    resolved_d = resolved_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (clear_i) begin
      valid_d    = '0;
      resolved_d = '0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      if (res_i) resolved_d[res_tag_i] = 1'b1;
      if (pop_i) begin
        valid_d[head_q]    = 1'b0;
        resolved_d[head_q] = 1'b0;
        head_d             = head_q + TAG_W'(1);
      end
      if (push_i) begin
        valid_d[tail_q]    = 1'b1;
        resolved_d[tail_q] = 1'b0;
        tail_d             = tail_q + TAG_W'(1);
      end
      unique case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q    <= '0;
      resolved_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      valid_q    <= valid_d;
      resolved_q <= resolved_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Payload storage; only meaningful while the matching valid bit is set
  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) entry_q[tail_q] <= push_entry_i;
    if (res_i && !clear_i)  actual_q[res_tag_i] <= res_taken_i;
  end

  assign head_o          = head_q;
  assign tail_o          = tail_q;
  assign count_o         = count_q;
  assign full_o          = (count_q == CNT_W'(DEPTH));
  assign res_open_o      = valid_q[res_tag_i] & ~resolved_q[res_tag_i];
  assign head_valid_o    = valid_q[head_q];
  assign head_resolved_o = resolved_q[head_q];
  assign head_entry_o    = entry_q[head_q];
  assign head_actual_o   = actual_q[head_q];

endmodule

// File: rtl/branch_outcome_tracker.sv
// Branch outcome tracker: queues predicted branches from fetch, accepts
// out-of-order resolutions by tag, retires in order and issues one predictor
// update per retire; a mispredicting retire also flushes and redirects.
// Ports: clk_in/rst_n_in (async active-low), rdy_in (pause), pred_* push side,
// res_* resolve side, upd_* predictor update, flush_out/redirect_pc_out,
// count_out occupancy, stat_* retire/mispredict counters.
// Optional: define BRANCH_STATS_EN to build the statistics counters; otherwise
// the stat ports read zero.
module branch_outcome_tracker
  import branch_outcome_tracker_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_QUEUE_DEPTH,
  parameter int unsigned TAG_W = DEF_TAG_W
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             rdy_in,
  input  logic             pred_valid_in,
  input  logic [31:0]      pred_pc_in,
  input  logic [31:0]      pred_target_in,
  input  logic             pred_taken_in,
  output logic             pred_ready_out,
  output logic [TAG_W-1:0] pred_tag_out,
  input  logic             res_valid_in,
  input  logic [TAG_W-1:0] res_tag_in,
  input  logic             res_taken_in,
  output logic             upd_valid_out,
  output logic [31:0]      upd_pc_out,
  output logic             upd_taken_out,
  output logic             flush_out,
  output logic [31:0]      redirect_pc_out,
  output logic [TAG_W:0]   count_out,
  output logic [31:0]      stat_branches_out,
  output logic [31:0]      stat_mispred_out
);

  logic [TAG_W-1:0] head, tail;
  logic [TAG_W:0]   count;
  logic             full, res_open, head_valid, head_resolved, head_actual;
  br_entry_t        head_entry, push_entry;

  logic res_hit_c, bypass_c, retire_c, actual_c, mispred_c, push_c;

  logic        upd_valid_q, upd_valid_d;
  logic [31:0] upd_pc_q, upd_pc_d;
  logic        upd_taken_q, upd_taken_d;
  logic        flush_q, flush_d;
  logic [31:0] redirect_q, redirect_d;

  assign push_entry = '{pc: pred_pc_in, target: pred_target_in, pred: pred_taken_in};

  // Retire decision; a resolve aimed at an unresolved head retires it at once
  always_comb begin
    res_hit_c      = rdy_in & res_valid_in & res_open;
    bypass_c       = res_hit_c & (res_tag_in == head);
    retire_c       = rdy_in & head_valid & (head_resolved | bypass_c);
    actual_c       = head_resolved ? head_actual : res_taken_in;
    mispred_c      = retire_c & (actual_c != head_entry.pred);
    // No look-ahead: a same-cycle retire does not free a slot for this push
    pred_ready_out = ~full & ~mispred_c;
    push_c         = rdy_in & pred_valid_in & pred_ready_out;
  end

  branch_tag_queue #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_queue (
    .clk_i           (clk_in),
    .rst_n_i         (rst_n_in),
    .push_i          (push_c),
    .push_entry_i    (push_entry),
    .res_i           (res_hit_c),
    .res_tag_i       (res_tag_in),
    .res_taken_i     (res_taken_in),
    .pop_i           (retire_c),
    .clear_i         (mispred_c),
    .head_o          (head),
    .tail_o          (tail),
    .count_o         (count),
    .full_o          (full),
    .res_open_o      (res_open),
    .head_valid_o    (head_valid),
    .head_resolved_o (head_resolved),
    .head_entry_o    (head_entry),
    .head_actual_o   (head_actual)
  );

  // Update/flush outputs; strobes clear each cycle, data holds between retires
  always_comb begin
    upd_valid_d = retire_c;
    upd_pc_d    = upd_pc_q;
    upd_taken_d = upd_taken_q;
    flush_d     = mispred_c;
    redirect_d  = redirect_q;
    if (retire_c) begin
      upd_pc_d    = head_entry.pc;
      upd_taken_d = actual_c;
    end
    if (mispred_c) redirect_d = redirect_pc(head_entry, actual_c);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      upd_valid_q <= 1'b0;
      upd_pc_q    <= '0;
      upd_taken_q <= 1'b0;
      flush_q     <= 1'b0;
      redirect_q  <= '0;
    end else begin
      upd_valid_q <= upd_valid_d;
      upd_pc_q    <= upd_pc_d;
      upd_taken_q <= upd_taken_d;
      flush_q     <= flush_d;
      redirect_q  <= redirect_d;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_br_q, stat_br_d;
  logic [31:0] stat_mis_q, stat_mis_d;

  // Free-running wrap counters stepped on the retire edge
  always_comb begin
    stat_br_d  = stat_br_q;
    stat_mis_d = stat_mis_q;
    if (retire_c)  stat_br_d  = stat_br_q + 32'd1;
    if (mispred_c) stat_mis_d = stat_mis_q + 32'd1;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      stat_br_q  <= '0;
      stat_mis_q <= '0;
    end else begin
      stat_br_q  <= stat_br_d;
      stat_mis_q <= stat_mis_d;
    end
  end

  assign stat_branches_out = stat_br_q;
  assign stat_mispred_out  = stat_mis_q;
`else
  assign stat_branches_out = 32'd0;
  assign stat_mispred_out  = 32'd0;
`endif

  assign pred_tag_out    = tail;
  assign count_out       = count;
  assign upd_valid_out   = upd_valid_q;
  assign upd_pc_out      = upd_pc_q;
  assign upd_taken_out   = upd_taken_q;
  assign flush_out       = flush_q;
  assign redirect_pc_out = redirect_q;

endmodule

// File: tb/tb_branch_outcome_tracker.sv
// Directed bench for branch_outcome_tracker with an update scoreboard.
module tb_branch_outcome_tracker;

`ifdef BRANCH_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        pred_valid_in;
  logic [31:0] pred_pc_in;
  logic [31:0] pred_target_in;
  logic        pred_taken_in;
  logic        pred_ready_out;
  logic [2:0]  pred_tag_out;
  logic        res_valid_in;
  logic [2:0]  res_tag_in;
  logic        res_taken_in;
  logic        upd_valid_out;
  logic [31:0] upd_pc_out;
  logic        upd_taken_out;
  logic        flush_out;
  logic [31:0] redirect_pc_out;
  logic [3:0]  count_out;
  logic [31:0] stat_branches_out;
  logic [31:0] stat_mispred_out;

  branch_outcome_tracker #(.DEPTH(8), .TAG_W(3)) dut (
    .clk_in            (clk_in),
    .rst_n_in          (rst_n_in),
    .rdy_in            (rdy_in),
    .pred_valid_in     (pred_valid_in),
    .pred_pc_in        (pred_pc_in),
    .pred_target_in    (pred_target_in),
    .pred_taken_in     (pred_taken_in),
    .pred_ready_out    (pred_ready_out),
    .pred_tag_out      (pred_tag_out),
    .res_valid_in      (res_valid_in),
    .res_tag_in        (res_tag_in),
    .res_taken_in      (res_taken_in),
    .upd_valid_out     (upd_valid_out),
    .upd_pc_out        (upd_pc_out),
    .upd_taken_out     (upd_taken_out),
    .flush_out         (flush_out),
    .redirect_pc_out   (redirect_pc_out),
    .count_out         (count_out),
    .stat_branches_out (stat_branches_out),
    .stat_mispred_out  (stat_mispred_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int          cyc;
    logic [31:0] pc;
    logic        taken;
    logic        flush;
    logic [31:0] redir;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   exp_br  = 0;
  int   exp_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected predictor update for a retire of (pc,tgt,pred) resolved to act
  task automatic sb_add(input logic [31:0] pc, input logic [31:0] tgt,
                        input logic pred, input logic act, input int due);
    exp_t e;
    e.cyc   = due;
    e.pc    = pc;
    e.taken = act;
    e.flush = (pred != act);
    e.redir = act ? tgt : pc + 32'd4;
    exp_q.push_back(e);
    exp_br++;
    if (e.flush) exp_mis++;
  endtask

  // Advance one clock and check the update port against the scoreboard
  task automatic step();
    exp_t e;
    logic expv;
    @(posedge clk_in);
    #1;
    cyc++;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      chk("upd_due", 32'(exp_q[0].cyc), 32'(cyc));
      void'(exp_q.pop_front());
    end
    expv = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
    chk("upd_valid", 32'(upd_valid_out), 32'(expv));
    if (expv) begin
      e = exp_q.pop_front();
      chk("upd_pc", upd_pc_out, e.pc);
      chk("upd_taken", 32'(upd_taken_out), 32'(e.taken));
      chk("flush", 32'(flush_out), 32'(e.flush));
      if (e.flush) chk("redirect", redirect_pc_out, e.redir);
    end else begin
      chk("flush_idle", 32'(flush_out), 32'd0);
    end
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0;
    step();
    step();
    rst_n_in = 1'b1;
    exp_q.delete();
    exp_br  = 0;
    exp_mis = 0;
  endtask

  task automatic do_push(input logic [31:0] pc, input logic [31:0] tgt,
                         input logic pred, input logic [2:0] tag);
    pred_valid_in  = 1'b1;
    pred_pc_in     = pc;
    pred_target_in = tgt;
    pred_taken_in  = pred;
    #1;
    chk("push_ready", 32'(pred_ready_out), 32'd1);
    chk("push_tag", 32'(pred_tag_out), 32'(tag));
    step();
    pred_valid_in = 1'b0;
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, "_br"}, stat_branches_out, STATS_EN ? 32'(exp_br) : 32'd0);
    chk({tag, "_mis"}, stat_mispred_out, STATS_EN ? 32'(exp_mis) : 32'd0);
  endtask

  initial begin
    rst_n_in       = 1'b0;
    rdy_in         = 1'b1;
    pred_valid_in  = 1'b0;
    pred_pc_in     = '0;
    pred_target_in = '0;
    pred_taken_in  = 1'b0;
    res_valid_in   = 1'b0;
    res_tag_in     = '0;
    res_taken_in   = 1'b0;

    // Reset state
    do_reset();
    chk("rst_upd_pc", upd_pc_out, 32'd0);
    chk("rst_upd_taken", 32'(upd_taken_out), 32'd0);
    chk("rst_redirect", redirect_pc_out, 32'd0);
    chk("rst_count", 32'(count_out), 32'd0);
    chk("rst_ready", 32'(pred_ready_out), 32'd1);
    chk("rst_tag", 32'(pred_tag_out), 32'd0);
    chk_stats("rst_stat");

    // 1: single correct branch, bypass retire
    do_push(32'h100, 32'h200, 1'b1, 3'd0);
    chk("t1_count1", 32'(count_out), 32'd1);
    res_valid_in = 1'b1; res_tag_in = 3'd0; res_taken_in = 1'b1;
    sb_add(32'h100, 32'h200, 1'b1, 1'b1, cyc + 1);
    step();
    res_valid_in = 1'b0;
    chk("t1_count0", 32'(count_out), 32'd0);
    step();
    chk("t1_pc_hold", upd_pc_out, 32'h100);

    // 2: mispredict flush, younger entry discarded, same-cycle push dropped
    do_reset();
    do_push(32'h40, 32'h1000, 1'b1, 3'd0);
    do_push(32'h80, 32'h2000, 1'b0, 3'd1);
    chk("t2_count2", 32'(count_out), 32'd2);
    res_valid_in = 1'b1; res_tag_in = 3'd0; res_taken_in = 1'b0;
    pred_valid_in = 1'b1; pred_pc_in = 32'h300; pred_taken_in = 1'b0;
    sb_add(32'h40, 32'h1000, 1'b1, 1'b0, cyc + 1);
    #1;
    chk("t2_ready_flush", 32'(pred_ready_out), 32'd0);
    step();
    pred_valid_in = 1'b0;
    chk("t2_count0", 32'(count_out), 32'd0);
    chk("t2_tag0", 32'(pred_tag_out), 32'd0);
    chk_stats("t2_stat");
    res_valid_in = 1'b1; res_tag_in = 3'd1; res_taken_in = 1'b1;
    step();
    res_valid_in = 1'b0;
    chk("t2_dead_tag", 32'(count_out), 32'd0);

    // 3: out-of-order resolution, in-order retire
    do_reset();
    do_push(32'h500, 32'h600, 1'b0, 3'd0);
    do_push(32'h504, 32'h604, 1'b1, 3'd1);
    do_push(32'h508, 32'h608, 1'b0, 3'd2);
    res_valid_in = 1'b1; res_tag_in = 3'd2; res_taken_in = 1'b0;
    step();
    res_tag_in = 3'd1; res_taken_in = 1'b1;
    step();
    res_tag_in = 3'd1; res_taken_in = 1'b0;   // repeat resolve is ignored
    step();
    chk("t3_count3", 32'(count_out), 32'd3);
    res_tag_in = 3'd0; res_taken_in = 1'b0;
    sb_add(32'h500, 32'h600, 1'b0, 1'b0, cyc + 1);
    sb_add(32'h504, 32'h604, 1'b1, 1'b1, cyc + 2);
    sb_add(32'h508, 32'h608, 1'b0, 1'b0, cyc + 3);
    step();
    res_valid_in = 1'b0;
    step();
    step();
    chk("t3_count0", 32'(count_out), 32'd0);

    // 4: full boundary, no look-ahead on ready
    do_reset();
    for (int i = 0; i < 8; i++) do_push(32'h1000 + 32'(4 * i), 32'h2000, 1'b1, 3'(i));
    chk("t4_count8", 32'(count_out), 32'd8);
    chk("t4_ready_full", 32'(pred_ready_out), 32'd0);
    pred_valid_in = 1'b1; pred_pc_in = 32'h9999; pred_taken_in = 1'b1;
    step();
    chk("t4_drop_count", 32'(count_out), 32'd8);
    chk("t4_drop_tag", 32'(pred_tag_out), 32'd0);
    pred_pc_in = 32'h3000; pred_target_in = 32'h3800; pred_taken_in = 1'b0;
    res_valid_in = 1'b1; res_tag_in = 3'd0; res_taken_in = 1'b1;
    sb_add(32'h1000, 32'h2000, 1'b1, 1'b1, cyc + 1);
    #1;
    chk("t4_ready_nola", 32'(pred_ready_out), 32'd0);
    step();
    chk("t4_count7", 32'(count_out), 32'd7);
    chk("t4_ready_again", 32'(pred_ready_out), 32'd1);
    res_tag_in = 3'd1;
    sb_add(32'h1004, 32'h2000, 1'b1, 1'b1, cyc + 1);
    step();
    pred_valid_in = 1'b0;
    res_valid_in  = 1'b0;
    chk("t4_pushpop_cnt", 32'(count_out), 32'd7);
    chk("t4_pushpop_tag", 32'(pred_tag_out), 32'd1);
    do_push(32'h3004, 32'h3900, 1'b0, 3'd1);
    chk("t4_refill", 32'(count_out), 32'd8);
    for (int i = 2; i < 8; i++) begin
      res_valid_in = 1'b1; res_tag_in = 3'(i); res_taken_in = 1'b1;
      sb_add(32'h1000 + 32'(4 * i), 32'h2000, 1'b1, 1'b1, cyc + 1);
      step();
    end
    res_tag_in = 3'd0; res_taken_in = 1'b0;
    sb_add(32'h3000, 32'h3800, 1'b0, 1'b0, cyc + 1);
    step();
    res_valid_in = 1'b0;
    chk("t4_drain_cnt", 32'(count_out), 32'd1);

    // 5: pause freezes resolve and push
    do_reset();
    do_push(32'h700, 32'h800, 1'b0, 3'd0);
    rdy_in = 1'b0;
    res_valid_in = 1'b1; res_tag_in = 3'd0; res_taken_in = 1'b0;
    pred_valid_in = 1'b1; pred_pc_in = 32'h777;
    step();
    step();
    pred_valid_in = 1'b0;
    chk("t5_paused_cnt", 32'(count_out), 32'd1);
    rdy_in = 1'b1;
    res_taken_in = 1'b1;
    sb_add(32'h700, 32'h800, 1'b0, 1'b1, cyc + 1);
    step();
    res_valid_in = 1'b0;
    chk("t5_count0", 32'(count_out), 32'd0);

    // 6: asynchronous reset mid-queue
    do_push(32'hA00, 32'hB00, 1'b1, 3'd0);
    do_push(32'hA10, 32'hB10, 1'b1, 3'd1);
    do_push(32'hA20, 32'hB20, 1'b1, 3'd2);
    res_valid_in = 1'b1; res_tag_in = 3'd0; res_taken_in = 1'b1;
    sb_add(32'hA00, 32'hB00, 1'b1, 1'b1, cyc + 1);
    step();
    res_tag_in = 3'd2; res_taken_in = 1'b0;
    step();
    chk("t6_pre_cnt", 32'(count_out), 32'd2);
    chk("t6_pre_pc", upd_pc_out, 32'hA00);
    chk("t6_pre_redir", redirect_pc_out, 32'h800);
    chk_stats("t6_pre_stat");
    res_tag_in = 3'd1; res_taken_in = 1'b1;
    #2;
    rst_n_in = 1'b0;
    #1;
    exp_br = 0; exp_mis = 0;
    chk("t6_rst_valid", 32'(upd_valid_out), 32'd0);
    chk("t6_rst_pc", upd_pc_out, 32'd0);
    chk("t6_rst_taken", 32'(upd_taken_out), 32'd0);
    chk("t6_rst_flush", 32'(flush_out), 32'd0);
    chk("t6_rst_redir", redirect_pc_out, 32'd0);
    chk("t6_rst_cnt", 32'(count_out), 32'd0);
    chk("t6_rst_ready", 32'(pred_ready_out), 32'd1);
    chk("t6_rst_tag", 32'(pred_tag_out), 32'd0);
    chk_stats("t6_rst_stat");
    res_valid_in = 1'b0;
    step();
    rst_n_in = 1'b1;
    step();
    chk("t6_post_cnt", 32'(count_out), 32'd0);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
